// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
// Shared definitions for the push-button debouncer and its prescaler:
//   - state_e           : debouncer FSM state encoding
//   - DEF_SYNC_STAGES   : default synchroniser depth
//   - DEF_SAMPLE_DIV    : default clock cycles per sample tick
//   - DEF_STABLE_COUNT  : default number of agreeing ticks needed to accept
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

  // Debouncer states. IDLE_LOW/HIGH are the settled levels; the CHK states
  // count consecutive ticks that show the opposite value.
  typedef enum logic [1:0] {
    IDLE_LOW = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES  = 32'd2;
  localparam int unsigned DEF_SAMPLE_DIV   = 32'd1000;
  localparam int unsigned DEF_STABLE_COUNT = 32'd4;

endpackage : button_debouncer_pkg

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Free-running prescaler. Produces a one-cycle tick every DIV clock cycles,
// on the cycle where the internal count equals DIV-1 (every cycle when
// DIV == 1). The tick is registered; it is computed one cycle ahead from the
// next count so its timing matches a direct compare on the current count.
// Ports:
//   clk_i   input  1  clock
//   rst_i   input  1  synchronous reset, active-high (count returns to 0)
//   tick_o  output 1  sample strobe
// -----------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int unsigned DIV = 32'd1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned W = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [W-1:0] LAST = W'(DIV - 32'd1);
  // The count sits at 0 just after reset, so the tick is already due then
  // exactly when DIV == 1.
  localparam logic TICK_AT_RESET = (LAST == '0);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         tick_q;
  logic         tick_d;

  // Next count (wraps after LAST) and the tick that goes with it.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= TICK_AT_RESET;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule : sample_tick_gen

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronises a raw asynchronous button input, samples it once per prescaler
// tick and accepts a new level only after STABLE_COUNT consecutive ticks all
// show it. Emits registered one-cycle rise/fall pulses aligned with the first
// cycle o_level shows the new value.
// Ports:
//   i_clk         input  1  system clock
//   i_reset       input  1  synchronous reset, active-high
//   i_raw         input  1  raw asynchronous button input
//   o_level       output 1  debounced level
//   o_rise_pulse  output 1  one-cycle pulse on accepted 0->1
//   o_fall_pulse  output 1  one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);

  localparam int unsigned SW = (STABLE_COUNT > 32'd0) ? $clog2(STABLE_COUNT + 32'd1) : 32'd1;
  localparam logic [SW:0]   STABLE_LAST = (SW + 1)'(STABLE_COUNT);
  localparam logic [SW-1:0] STAB_ONE    = SW'(32'd1);
  // With a single required tick the CHK states are skipped entirely.
  localparam logic          ACCEPT_NOW  = (STABLE_COUNT == 32'd1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in_s;
  logic                   tick_s;

  state_e        state_q;
  state_e        state_d;
  logic [SW-1:0] stab_q;
  logic [SW-1:0] stab_d;
  logic [SW:0]   stab_inc_s;
  logic          level_q;
  logic          level_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  // Plain flop chain; nothing sits between the stages.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign sync_in_s = sync_q[SYNC_STAGES-1];

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .tick_o (tick_s)
  );

  // One extra bit so the compare against STABLE_COUNT cannot overflow.
  assign stab_inc_s = {1'b0, stab_q} + {{SW{1'b0}}, 1'b1};

  // Next-state, stability count and pulse decode; only tick cycles move the FSM.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_s) begin
      case (state_q)
        IDLE_LOW: begin
          if (sync_in_s) begin
            if (ACCEPT_NOW) begin
              state_d = HIGH;
              stab_d  = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = CHK_HIGH;
              stab_d  = STAB_ONE;
            end
          end else begin
            stab_d = '0;
          end
        end
        CHK_HIGH: begin
          if (!sync_in_s) begin
            state_d = IDLE_LOW;
            stab_d  = '0;
          end else if (stab_inc_s >= STABLE_LAST) begin
            state_d = HIGH;
            stab_d  = '0;
            rise_d  = 1'b1;
          end else begin
            stab_d = stab_inc_s[SW-1:0];
          end
        end
        HIGH: begin
          if (!sync_in_s) begin
            if (ACCEPT_NOW) begin
              state_d = IDLE_LOW;
              stab_d  = '0;
              fall_d  = 1'b1;
            end else begin
              state_d = CHK_LOW;
              stab_d  = STAB_ONE;
            end
          end else begin
            stab_d = '0;
          end
        end
        CHK_LOW: begin
          if (sync_in_s) begin
            state_d = HIGH;
            stab_d  = '0;
          end else if (stab_inc_s >= STABLE_LAST) begin
            state_d = IDLE_LOW;
            stab_d  = '0;
            fall_d  = 1'b1;
          end else begin
            stab_d = stab_inc_s[SW-1:0];
          end
        end
        default: begin
          state_d = IDLE_LOW;
          stab_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      stab_d  = stab_q;
    end
    // CHK_LOW still reports the accepted high level until the fall is accepted.
    level_d = (state_d == HIGH) || (state_d == CHK_LOW);
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE_LOW;
      stab_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level      = level_q;
  assign o_rise_pulse = rise_q;
  assign o_fall_pulse = fall_q;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
// Directed plus randomized bench for button_debouncer (SYNC=2, DIV=4,
// STABLE=3), with a second instance (DIV=1, STABLE=1) driving a bench-side
// 8-bit event counter.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int S   = 2;
  localparam int DIV = 4;
  localparam int K   = 3;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic raw_s = 1'b0;
  logic raw2_s = 1'b0;
  logic level, rise, fall;
  logic level2, rise2, fall2;
  logic [7:0] cnt2_q;

  int vectors = 0;
  int miscompares = 0;
  int n_rise = 0;
  int n_fall = 0;
  int cyc_total = 0;

  // Reference model: sync delay queue, tick phase, run of opposite samples.
  bit sq[$];
  bit m_level = 1'b0;
  bit m_rise = 1'b0;
  bit m_fall = 1'b0;
  int m_run = 0;
  int m_cyc = 0;

  always #5 clk = ~clk;

  button_debouncer #(.SYNC_STAGES(S), .SAMPLE_DIV(DIV), .STABLE_COUNT(K)) dut (
    .i_clk(clk), .i_reset(rst_s), .i_raw(raw_s),
    .o_level(level), .o_rise_pulse(rise), .o_fall_pulse(fall)
  );

  button_debouncer #(.SYNC_STAGES(2), .SAMPLE_DIV(1), .STABLE_COUNT(1)) dut2 (
    .i_clk(clk), .i_reset(rst_s), .i_raw(raw2_s),
    .o_level(level2), .o_rise_pulse(rise2), .o_fall_pulse(fall2)
  );

  // Stand-in for the downstream 8-bit event counter.
  always @(posedge clk) begin
    if (rst_s) cnt2_q <= 8'd0;
    else if (rise2) cnt2_q <= cnt2_q + 8'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input logic raw, input logic rst);
    bit sin;
    raw_s = raw;
    rst_s = rst;
    @(posedge clk);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) begin
      m_level = 1'b0;
      m_run = 0;
      m_cyc = 0;
      sq.delete();
      for (int i = 0; i < S; i++) sq.push_back(1'b0);
    end else begin
      sin = sq.pop_front();
      sq.push_back(raw);
      if ((m_cyc % DIV) == DIV - 1) begin
        if (sin != m_level) m_run++;
        else m_run = 0;
        if (m_run >= K) begin
          m_level = ~m_level;
          m_rise = m_level;
          m_fall = ~m_level;
          m_run = 0;
        end
      end
      m_cyc++;
    end
    @(negedge clk);
    cyc_total++;
    vectors++;
    assert ({level, rise, fall} === {m_level, m_rise, m_fall}) else begin
      miscompares++;
      $error("FAIL outputs@%0d: observed lvl/rise/fall=%b%b%b expected %b%b%b",
             cyc_total, level, rise, fall, m_level, m_rise, m_fall);
    end
    if (rise === 1'b1) n_rise++;
    if (fall === 1'b1) n_fall++;
  endtask

  initial begin
    int hold;
    bit val;
    @(negedge clk);

    // Reset held with raw high: everything stays low.
    repeat (3) step(1'b1, 1'b1);
    check("reset_outputs", int'({level, rise, fall}), 0);
    n_rise = 0;
    repeat (15) step(1'b1, 1'b0);
    check("reset_release_rise", n_rise, 1);
    check("reset_release_level", int'(level), 1);

    // Clean release then clean press and release.
    repeat (40) step(1'b0, 1'b0);
    n_rise = 0; n_fall = 0;
    repeat (40) step(1'b1, 1'b0);
    check("press_rise", n_rise, 1);
    check("press_nofall", n_fall, 0);
    check("press_level", int'(level), 1);
    n_rise = 0; n_fall = 0;
    repeat (40) step(1'b0, 1'b0);
    check("release_fall", n_fall, 1);
    check("release_norise", n_rise, 0);

    // Bounce every 3 cycles, then settle high.
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 30; i++) step(((i / 3) % 2) == 0, 1'b0);
    check("bounce_norise", n_rise, 0);
    check("bounce_nofall", n_fall, 0);
    check("bounce_level", int'(level), 0);
    repeat (15) step(1'b1, 1'b0);
    check("settle_rise", n_rise, 1);
    repeat (40) step(1'b0, 1'b0);

    // Short glitch.
    n_rise = 0; n_fall = 0;
    repeat (5) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    check("glitch_pulses", n_rise + n_fall, 0);
    check("glitch_level", int'(level), 0);

    // Reset after two accepted ticks, then full requalification.
    step(1'b0, 1'b1);
    n_rise = 0;
    repeat (9) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midcheck_reset_out", int'({level, rise, fall}), 0);
    check("midcheck_norise", n_rise, 0);
    repeat (11) step(1'b1, 1'b0);
    check("requal_early", n_rise, 0);
    step(1'b1, 1'b0);
    check("requal_rise", int'(rise), 1);
    // Reset landing on the pulse cycle.
    step(1'b1, 1'b1);
    check("pulse_reset_out", int'({level, rise, fall}), 0);
    n_rise = 0;
    repeat (15) step(1'b1, 1'b0);
    check("pulse_reset_requal", n_rise, 1);
    repeat (40) step(1'b0, 1'b0);

    // Random hold lengths with occasional resets.
    for (int i = 0; i < 60; i++) begin
      hold = int'($urandom_range(1, 20));
      val = bit'($urandom_range(0, 1));
      for (int j = 0; j < hold; j++) step(val, $urandom_range(0, 49) == 0);
    end

    // Counter integration through the fast instance.
    raw2_s = 1'b0;
    repeat (2) step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      raw2_s = 1'b1;
      repeat (6) step(1'b0, 1'b0);
      raw2_s = 1'b0;
      repeat (6) step(1'b0, 1'b0);
    end
    check("counter_count", int'(cnt2_q), 5);
    check("counter_level", int'(level2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_button_debouncer

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the 8-bit event counter.
- Takes one raw, bouncy, asynchronous push-button or switch input from a ui_in pin and synchronises it. It filters out bounce and produces:
  - a clean level;
  - single-cycle rise and fall pulses.
- o_rise_pulse drives the counter's enable directly, so each physical press advances the count by exactly 1.

Parameters:
- SYNC_STAGES, 2: flip-flops in the input synchroniser chain; legal range >= 2.
- SAMPLE_DIV, 1000: clock cycles per sample tick; legal range >= 1. A value of 1 samples every cycle.
- STABLE_COUNT, 4: consecutive sample ticks that must all show the new value before it is accepted; legal range >= 1.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous reset, active-high.
- i_raw  input  1  raw asynchronous button input.
- o_level  output  1  debounced level.
- o_rise_pulse  output  1  one-cycle pulse when o_level is accepted 0->1.
- o_fall_pulse  output  1  one-cycle pulse when o_level is accepted 1->0.

Behaviour:
- Clocking and reset:
  - One clock domain: i_clk.
  - Reset is synchronous and active-high (i_reset), sampled on the rising edge of i_clk.
  - Reset values: synchroniser all 0, tick counter 0, stability counter 0, state IDLE_LOW, o_level 0, o_rise_pulse 0, o_fall_pulse 0.
- Synchroniser:
  - i_raw passes through SYNC_STAGES flops. Call the output sync_in.
  - No logic is placed between the stages.
- Tick generator:
  - Counter of width max(1, $clog2(SAMPLE_DIV)), free-running from reset.
  - tick=1 for one cycle when the count equals SAMPLE_DIV-1; the count then wraps to 0.
  - SAMPLE_DIV=1 gives tick=1 on every cycle.
- State machine: four states, all evaluated only on cycles where tick=1.
  - IDLE_LOW (o_level=0): if sync_in=1, go to CHK_HIGH with stab_cnt=1.
  - CHK_HIGH:
    - sync_in=0: return to IDLE_LOW and clear stab_cnt (bounce rejected).
    - sync_in=1 and stab_cnt+1 < STABLE_COUNT: increment stab_cnt.
    - sync_in=1 and stab_cnt+1 = STABLE_COUNT: accept; go to HIGH.
  - HIGH (o_level=1): mirror of IDLE_LOW; on sync_in=0 go to CHK_LOW.
  - CHK_LOW: mirror of CHK_HIGH; accepts into IDLE_LOW and returns to HIGH on bounce.
  - STABLE_COUNT=1: the first tick showing the new value accepts immediately, going straight from IDLE_LOW to HIGH (or HIGH to IDLE_LOW). The CHK states are not visited.
- Outputs:
  - All outputs are registered.
  - o_level changes on the clock edge of the accepting tick.
  - o_rise_pulse / o_fall_pulse are high for exactly the one cycle in which o_level first shows the new value. They are never high together and never high for two consecutive cycles.
- Latency:
  - From a clean i_raw step to the o_level change: between SYNC_STAGES + (STABLE_COUNT-1)*SAMPLE_DIV + 1 and SYNC_STAGES + STABLE_COUNT*SAMPLE_DIV + 1 cycles, depending on tick phase.
- Widths:
  - stab_cnt width is max(1, $clog2(STABLE_COUNT+1)). It saturates by construction and never wraps.
- Boundary conditions:
  - Input toggles that change faster than STABLE_COUNT ticks produce no pulse, and o_level holds.
  - Reset asserted in any state, including mid-check or during a pulse cycle, returns all outputs to 0 on the next edge. If i_raw is held high through reset release, the block must then re-qualify it from IDLE_LOW and emit o_rise_pulse.
  - sync_in changes between ticks are ignored. Only the value on the tick cycle matters.

Decomposition:
- Shared header: state encoding localparams (IDLE_LOW=2'd0, CHK_HIGH=2'd1, HIGH=2'd2, CHK_LOW=2'd3).
- Shared header: default parameter values, shared with the top-level instantiation.
- One natural sub-module: sample_tick_gen, which is the SAMPLE_DIV counter producing tick. It is reusable by other prescaled logic.
- Synchroniser and FSM stay inline.

Test Plan (SYNC_STAGES=2, SAMPLE_DIV=4, STABLE_COUNT=3 unless stated):
- Reset: hold i_reset=1 for 3 cycles with i_raw=1 -> all outputs 0 throughout. After release, o_level rises within 2+12+1=15 cycles, with exactly one o_rise_pulse.
- Clean press: i_raw 0->1 held 40 cycles, then 1->0 held 40 cycles -> exactly one o_rise_pulse, later exactly one o_fall_pulse. o_level is 1 between the two pulses.
- Bounce: i_raw toggles every 3 cycles for 30 cycles, then settles at 1 -> no pulse during toggling; a single o_rise_pulse at most 15 cycles after settling.
- Short glitch: i_raw=1 for 5 cycles only -> o_level stays 0 and no pulses.
- Reset mid-check: i_raw=1; assert i_reset for 1 cycle after 2 accepted ticks -> counters cleared and no pulse during reset. After release, full requalification is needed: 3 fresh ticks before o_rise_pulse.
- Counter integration: SAMPLE_DIV=1, STABLE_COUNT=1, o_rise_pulse feeding counter_8bit; apply 5 clean presses -> count_out = 8'd5.
